// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: FSM encodings, default width, iteration helpers.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package div_iter_pkg;

    // Default operand width, kept in step with the multiplier block
    localparam int DIV_WIDTH_DEFAULT = 32;

    // FSM encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Number of RUN cycles for a given width / bits-per-cycle
    function automatic int iter_count(input int width, input int unroll);
        return width / unroll;
    endfunction

    // Counter width able to hold ITER-1 (never narrower than one bit)
    function automatic int cnt_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Command/result bundle between the control unit (master) and the divider (slave).
// Latency: n/a (wires only).
// Backpressure: start is only honoured while busy is low; there is no queueing.
interface div_iter_if import div_iter_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, src_a, src_b,
        input  busy, done, div_zero, overflow, hi, lo
    );

    modport slave (
        input  start, is_signed, src_a, src_b,
        output busy, done, div_zero, overflow, hi, lo
    );
endinterface

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    // Shifted remainder kept one bit wider so divisors >= 2^(WIDTH-1) compare correctly
    logic [WIDTH:0] shifted;

    // Compare on WIDTH+1 bits; after a subtract the result is < divisor and fits WIDTH
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider (signed/unsigned), UNROLL quotient bits per cycle.
// Latency: WIDTH/UNROLL + 1 cycles after the start edge; divide-by-zero and MIN/-1 take 1 cycle.
// Backpressure: busy high while an op is in flight; start is ignored then, accepted again in the done cycle.
module div_iter import div_iter_pkg::*; #(
    parameter int WIDTH  = DIV_WIDTH_DEFAULT,
    parameter int UNROLL = 1
) (
    input  logic       clk,
    input  logic       rst,
    div_iter_if.slave  bus
);
    localparam int               ITER     = iter_count(WIDTH, UNROLL);
    localparam int               CNT_W    = cnt_width(ITER);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] dvd_q,      dvd_d;      // dividend, becomes quotient as bits shift through
    logic [WIDTH-1:0] dvs_q,      dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] rem_q,      rem_d;      // partial remainder
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;
    logic             pend_dz_q,  pend_dz_d;  // FIX should report divide-by-zero
    logic             pend_ovf_q, pend_ovf_d; // FIX should report MIN / -1
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic             dz_q,       dz_d;
    logic             ovf_q,      ovf_d;
    logic             done_q,     done_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             b_zero, ovf_case;
    logic [WIDTH-1:0] rem_chain [UNROLL+1];
    logic [UNROLL-1:0] quo_bits;
    logic [WIDTH-1:0] dvd_next;

    // Operand decode: signs only matter in signed mode; -MIN wraps to the correct unsigned magnitude
    always_comb begin
        sign_a   = bus.is_signed & bus.src_a[WIDTH-1];
        sign_b   = bus.is_signed & bus.src_b[WIDTH-1];
        mag_a    = sign_a ? -bus.src_a : bus.src_a;
        mag_b    = sign_b ? -bus.src_b : bus.src_b;
        b_zero   = (bus.src_b == '0);
        ovf_case = bus.is_signed && (bus.src_a == MIN_VAL) && (bus.src_b == '1);
    end

    // Chain UNROLL restoring steps, consuming dividend bits MSB-first
    assign rem_chain[0] = rem_q;
    for (genvar u = 0; u < UNROLL; u++) begin : g_step
        div_iter_step #(.WIDTH(WIDTH)) u_step (
            .rem_i     (rem_chain[u]),
            .bit_i     (dvd_q[WIDTH-1-u]),
            .divisor_i (dvs_q),
            .rem_o     (rem_chain[u+1]),
            .qbit_o    (quo_bits[UNROLL-1-u])
        );
    end

    // Consumed dividend bits shift out the top while quotient bits fill in from the bottom
    always_comb begin
        dvd_next = (dvd_q << UNROLL) | WIDTH'(quo_bits);
    end

    // FSM and datapath next-state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        pend_dz_d  = pend_dz_q;
        pend_ovf_d = pend_ovf_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dz_d       = 1'b0;
                    ovf_d      = 1'b0;
                    neg_quo_d  = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    pend_dz_d  = b_zero;
                    pend_ovf_d = ovf_case;
                    if (b_zero || ovf_case) begin
                        state_d = S_FIX;
                    end else begin
                        dvd_d   = mag_a;
                        dvs_d   = mag_b;
                        rem_d   = '0;
                        cnt_d   = CNT_LOAD;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                dvd_d = dvd_next;
                rem_d = rem_chain[UNROLL];
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (pend_dz_q) begin
                    dz_d = 1'b1;
                end else if (pend_ovf_q) begin
                    ovf_d = 1'b1;
                    lo_d  = MIN_VAL;
                    hi_d  = '0;
                end else begin
                    lo_d = neg_quo_q ? -dvd_q : dvd_q;
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            pend_dz_q  <= 1'b0;
            pend_ovf_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            pend_dz_q  <= pend_dz_d;
            pend_ovf_q <= pend_ovf_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.overflow = ovf_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter at W=32/U=1 and W=16/U=4.
// Latency: checks done timing per op.
// Backpressure: exercises start-while-busy and start-in-done-cycle.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   lat;
    int   spur;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) bus32 ();
    div_iter_if #(.WIDTH(16)) bus16 ();

    div_iter #(.WIDTH(32), .UNROLL(1)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    div_iter #(.WIDTH(16), .UNROLL(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then scramble operands (they only need to be stable at the start edge)
    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus32.src_a = a; bus32.src_b = b; bus32.is_signed = s; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.src_a = $urandom; bus32.src_b = $urandom;
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic s);
        bus16.src_a = a; bus16.src_b = b; bus16.is_signed = s; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus16.src_a = 16'($urandom); bus16.src_b = 16'($urandom);
    endtask

    // Count edges after the start edge until done; 0 means it never came
    task automatic wait32(input int elapsed, output int l);
        l = 0;
        for (int i = elapsed + 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus32.done) begin l = i; break; end
        end
    endtask

    task automatic wait16(output int l);
        l = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus16.done) begin l = i; break; end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.src_a = '0; bus32.src_b = '0;
        bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.src_a = '0; bus16.src_b = '0;
        @(posedge clk); #3;
        chk("rst_busy", bus32.busy, 0);
        chk("rst_done", bus32.done, 0);
        chk("rst_dz", bus32.div_zero, 0);
        chk("rst_ovf", bus32.overflow, 0);
        chk("rst_hi", bus32.hi, 0);
        chk("rst_lo", bus32.lo, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Unsigned 100/7
        go32(32'd100, 32'd7, 1'b0);
        chk("busy_after_start", bus32.busy, 1);
        wait32(0, lat);
        chk("u100_7_lat", lat, 33);
        chk("u100_7_lo", bus32.lo, 14);
        chk("u100_7_hi", bus32.hi, 2);
        chk("u100_7_busy", bus32.busy, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", bus32.done, 0);

        // Signed -7/2 and 7/-2
        go32(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait32(0, lat);
        chk("s-7_2_lo", bus32.lo, 32'hFFFF_FFFD);
        chk("s-7_2_hi", bus32.hi, 32'hFFFF_FFFF);
        go32(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait32(0, lat);
        chk("s7_-2_lo", bus32.lo, 32'hFFFF_FFFD);
        chk("s7_-2_hi", bus32.hi, 32'd1);

        // Divide by zero keeps previous hi/lo
        go32(32'd59, 32'd6, 1'b0);
        wait32(0, lat);
        chk("u59_6_lo", bus32.lo, 9);
        chk("u59_6_hi", bus32.hi, 5);
        go32(32'd1234, 32'd0, 1'b0);
        wait32(0, lat);
        chk("dz_lat", lat, 1);
        chk("dz_flag", bus32.div_zero, 1);
        chk("dz_hi_kept", bus32.hi, 5);
        chk("dz_lo_kept", bus32.lo, 9);
        chk("dz_busy", bus32.busy, 0);
        go32(32'd20, 32'd4, 1'b0);
        wait32(0, lat);
        chk("dz_cleared", bus32.div_zero, 0);
        chk("u20_4_lo", bus32.lo, 5);
        chk("u20_4_hi", bus32.hi, 0);

        // Signed overflow, then same operands unsigned
        go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait32(0, lat);
        chk("ovf_lat", lat, 1);
        chk("ovf_flag", bus32.overflow, 1);
        chk("ovf_lo", bus32.lo, 32'h8000_0000);
        chk("ovf_hi", bus32.hi, 0);
        go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait32(0, lat);
        chk("umin_lat", lat, 33);
        chk("umin_ovf", bus32.overflow, 0);
        chk("umin_lo", bus32.lo, 0);
        chk("umin_hi", bus32.hi, 32'h8000_0000);

        // Zero dividend takes full latency
        go32(32'd0, 32'd5, 1'b1);
        wait32(0, lat);
        chk("zero_lat", lat, 33);
        chk("zero_lo", bus32.lo, 0);
        chk("zero_hi", bus32.hi, 0);

        // Large divisor (top bit set)
        go32(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        wait32(0, lat);
        chk("bigdiv_lo", bus32.lo, 1);
        chk("bigdiv_hi", bus32.hi, 32'h7FFF_FFFF);

        // Reset mid-operation
        go32(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus32.busy, 0);
        chk("midrst_lo", bus32.lo, 0);
        chk("midrst_hi", bus32.hi, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        spur = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.done) spur++;
        end
        chk("no_spurious_done", spur, 0);

        // Start while busy is ignored
        go32(32'hFFFF_FFFF, 32'd1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus32.src_a = 32'd10; bus32.src_b = 32'd3; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        wait32(5, lat);
        chk("ign_lat", lat, 33);
        chk("ign_lo", bus32.lo, 32'hFFFF_FFFF);
        chk("ign_hi", bus32.hi, 0);

        // Back-to-back start in the done cycle
        chk("b2b_busy_in_done", bus32.busy, 0);
        go32(32'd10, 32'd3, 1'b0);
        wait32(0, lat);
        chk("b2b_lat", lat, 33);
        chk("b2b_lo", bus32.lo, 3);
        chk("b2b_hi", bus32.hi, 1);

        // W=16, U=4: done 5 cycles after start
        go16(16'hFFFF, 16'd3, 1'b0);
        wait16(lat);
        chk("w16_lat", lat, 5);
        chk("w16_u_lo", bus16.lo, 16'h5555);
        chk("w16_u_hi", bus16.hi, 0);
        go16(16'hFF9C, 16'd7, 1'b1);
        wait16(lat);
        chk("w16_s_lat", lat, 5);
        chk("w16_s_lo", bus16.lo, 16'hFFF2);
        chk("w16_s_hi", bus16.hi, 16'hFFFE);
        go16(16'hFFFF, 16'h8001, 1'b0);
        wait16(lat);
        chk("w16_big_lo", bus16.lo, 1);
        chk("w16_big_hi", bus16.hi, 16'h7FFE);
        go16(16'd7, 16'hFFFE, 1'b1);
        wait16(lat);
        chk("w16_s2_lo", bus16.lo, 16'hFFFD);
        chk("w16_s2_hi", bus16.hi, 1);
        go16(16'h8000, 16'hFFFF, 1'b1);
        wait16(lat);
        chk("w16_ovf_lat", lat, 1);
        chk("w16_ovf", bus16.overflow, 1);
        chk("w16_ovf_lo", bus16.lo, 16'h8000);
        chk("w16_ovf_hi", bus16.hi, 0);
        go16(16'd0, 16'd5, 1'b0);
        wait16(lat);
        chk("w16_zero_lat", lat, 5);
        chk("w16_zero_lo", bus16.lo, 0);
        chk("w16_zero_ovf", bus16.overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
